// File: rtl/pattern_match_cnt.sv
// Windowed 4-tap pattern matcher with fill tracking and saturating count.
// Define PATTERN_MATCH_OVERLAP_EN to count overlapping occurrences (no BLANK).
module pattern_match_cnt #(
    parameter logic [3:0] PATTERN = 4'b1011,
    parameter int         CNT_W   = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             en,
    input  logic             clr,
    input  logic [3:0]       tap,
    output logic             win_valid,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

`ifdef PATTERN_MATCH_OVERLAP_EN
    typedef enum logic {FILL, ARMED} state_t;
`else
    typedef enum logic [1:0] {FILL, ARMED, BLANK} state_t;
    logic [1:0] blank_q, blank_d;
`endif

    state_t           state_q, state_d;
    logic [2:0]       fill_q, fill_d;
    logic             match_q, match_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic             hit;

    assign hit = (tap == PATTERN);

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        match_d = 1'b0;
        cnt_d   = cnt_q;
`ifndef PATTERN_MATCH_OVERLAP_EN
        blank_d = blank_q;
`endif
        if (en && fill_q != 3'd4) begin
            fill_d = fill_q + 3'd1;
        end
        if (en) begin
            unique case (state_q)
                FILL: begin
                    if (fill_d == 3'd4) state_d = ARMED;
                end
                ARMED: begin
                    if (hit && !clr) begin
                        match_d = 1'b1;
                        if (!sat_q) cnt_d = cnt_q + 1'b1;
`ifndef PATTERN_MATCH_OVERLAP_EN
                        state_d = BLANK;
                        blank_d = 2'd3;
`endif
                    end
                end
`ifndef PATTERN_MATCH_OVERLAP_EN
                BLANK: begin
                    blank_d = blank_q - 2'd1;
                    if (blank_q == 2'd1) state_d = ARMED;
                end
`endif
                default: ;
            endcase
        end
        // Clear wins over any compare made on the same edge.
        if (clr) begin
            cnt_d   = '0;
            match_d = 1'b0;
`ifndef PATTERN_MATCH_OVERLAP_EN
            if (state_q == BLANK) begin
                state_d = ARMED;
                blank_d = 2'd0;
            end
`endif
        end
        sat_d = &cnt_d;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= FILL;
            fill_q  <= 3'd0;
            match_q <= 1'b0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
`ifndef PATTERN_MATCH_OVERLAP_EN
            blank_q <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            match_q <= match_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
`ifndef PATTERN_MATCH_OVERLAP_EN
            blank_q <= blank_d;
`endif
        end
    end

    assign win_valid = (fill_q == 3'd4);
    assign match     = match_q;
    assign match_cnt = cnt_q;
    assign cnt_sat   = sat_q;

endmodule

// File: tb/tb_pattern_match_cnt.sv
// Scoreboard bench: directed steps queue expected outputs, a monitor checks them.
module tb_pattern_match_cnt;

`ifdef PATTERN_MATCH_OVERLAP_EN
    localparam int OVL = 1;
`else
    localparam int OVL = 0;
`endif

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic en0 = 1'b0, clr0 = 1'b0;
    logic [3:0] tap0 = 4'd0;
    logic en1 = 1'b0, clr1 = 1'b0;
    logic [3:0] tap1 = 4'd0;
    logic wv0, m0, sat0, wv1, m1, sat1;
    logic [7:0] cnt0;
    logic [1:0] cnt1;

    int checks = 0;
    int errors = 0;
    int stepno = 0;

    typedef struct {
        int         id;
        int         tag;
        logic [10:0] exp;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    pattern_match_cnt #(.PATTERN(4'b1011), .CNT_W(8)) u0 (
        .clk(clk), .n_rst(n_rst), .en(en0), .clr(clr0), .tap(tap0),
        .win_valid(wv0), .match(m0), .match_cnt(cnt0), .cnt_sat(sat0)
    );

    pattern_match_cnt #(.PATTERN(4'b0000), .CNT_W(2)) u1 (
        .clk(clk), .n_rst(n_rst), .en(en1), .clr(clr1), .tap(tap1),
        .win_valid(wv1), .match(m1), .match_cnt(cnt1), .cnt_sat(sat1)
    );

    function automatic logic [10:0] pack(input logic wv, input logic m,
                                         input logic [7:0] c, input logic s);
        return {wv, m, c, s};
    endfunction

    task automatic chk(input string nm, input logic [10:0] act,
                       input logic [10:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got wv=%b m=%b cnt=%0d sat=%b want wv=%b m=%b cnt=%0d sat=%b",
                     nm, act[10], act[9], act[8:1], act[0],
                     exp[10], exp[9], exp[8:1], exp[0]);
        end
    endtask

    function automatic logic [10:0] dut_out(input int id);
        if (id == 0) return pack(wv0, m0, cnt0, sat0);
        return pack(wv1, m1, {6'd0, cnt1}, sat1);
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk($sformatf("dut%0d_step%0d", e.id, e.tag), dut_out(e.id), e.exp);
            end
        end
    end

    task automatic step(input int id, input logic e, input logic c,
                        input logic [3:0] t, input logic wv, input logic m,
                        input int cnt, input logic s);
        exp_t x;
        @(negedge clk);
        #1;
        if (id == 0) begin
            en0 = e; clr0 = c; tap0 = t; en1 = 1'b0; clr1 = 1'b0;
        end else begin
            en1 = e; clr1 = c; tap1 = t; en0 = 1'b0; clr0 = 1'b0;
        end
        stepno++;
        x.id  = id;
        x.tag = stepno;
        x.exp = pack(wv, m, 8'(cnt), s);
        sb.push_back(x);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    localparam logic [3:0] P = 4'b1011;
    localparam logic [3:0] Z = 4'b0000;

    initial begin : stim
        int c, d, k;
        #2;
        chk("reset_state0", dut_out(0), pack(1'b0, 1'b0, 8'd0, 1'b0));
        chk("reset_state1", dut_out(1), pack(1'b0, 1'b0, 8'd0, 1'b0));
        #1 n_rst = 1'b1;

        // Fill with a matching window held from the first edge.
        step(0, 1, 0, P, 0, 0, 0, 0);
        step(0, 1, 0, P, 0, 0, 0, 0);
        step(0, 1, 0, P, 0, 0, 0, 0);
        step(0, 1, 0, P, 1, 0, 0, 0);
        step(0, 1, 0, P, 1, 1, 1, 0);
        // Clear beats a match, then the next match counts from zero.
        step(0, 1, 1, P, 1, 0, 0, 0);
        step(0, 1, 0, P, 1, 1, 1, 0);
        step(0, 1, 0, Z, 1, 0, 1, 0);
        step(0, 1, 0, Z, 1, 0, 1, 0);
        step(0, 1, 0, Z, 1, 0, 1, 0);
        step(0, 1, 1, P, 1, 0, 0, 0);
        step(0, 1, 0, P, 1, 1, 1, 0);
        // Idle cycles inside the blanking window.
        step(0, 1, 0, Z, 1, 0, 1, 0);
        step(0, 0, 0, P, 1, 0, 1, 0);
        step(0, 1, 0, P, 1, 1'(OVL), 1 + OVL, 0);
        step(0, 0, 0, P, 1, 0, 1 + OVL, 0);
        step(0, 1, 0, Z, 1, 0, 1 + OVL, 0);
        c = 2 + OVL;
        step(0, 1, 0, P, 1, 1, c, 0);
        step(0, 1, 0, Z, 1, 0, c, 0);
        step(0, 1, 0, Z, 1, 0, c, 0);
        step(0, 1, 0, Z, 1, 0, c, 0);
        // Serial stream 1,0,1,1,0,1,1 shifted into the window.
        step(0, 1, 0, 4'b0001, 1, 0, c, 0);
        step(0, 1, 0, 4'b0010, 1, 0, c, 0);
        step(0, 1, 0, 4'b0101, 1, 0, c, 0);
        step(0, 1, 0, 4'b1011, 1, 1, c + 1, 0);
        step(0, 1, 0, 4'b0110, 1, 0, c + 1, 0);
        step(0, 1, 0, 4'b1101, 1, 0, c + 1, 0);
        step(0, 1, 0, 4'b1011, 1, 1'(OVL), c + 1 + OVL, 0);
        d = c + 1 + OVL;
        step(0, 1, 0, P, 1, 1, d + 1, 0);
        step(0, 1, 0, Z, 1, 0, d + 1, 0);
        step(0, 1, 0, Z, 1, 0, d + 1, 0);
        step(0, 1, 0, Z, 1, 0, d + 1, 0);
        step(0, 1, 0, P, 1, 1, d + 2, 0);
        step(0, 1, 0, Z, 1, 0, d + 2, 0);
        step(0, 1, 0, Z, 1, 0, d + 2, 0);
        step(0, 1, 0, Z, 1, 0, d + 2, 0);

        // Asynchronous reset pulse mid-cycle.
        @(negedge clk);
        en0 = 1'b0;
        #1 n_rst = 1'b0;
        #1 chk("async_reset", dut_out(0), pack(1'b0, 1'b0, 8'd0, 1'b0));
        #2 n_rst = 1'b1;
        step(0, 1, 0, P, 0, 0, 0, 0);
        step(0, 1, 0, P, 0, 0, 0, 0);
        step(0, 1, 0, P, 0, 0, 0, 0);
        step(0, 1, 0, P, 1, 0, 0, 0);
        step(0, 1, 0, P, 1, 1, 1, 0);

        // Saturation on the 2-bit, all-zero pattern instance.
        step(1, 1, 0, Z, 0, 0, 0, 0);
        step(1, 1, 0, Z, 0, 0, 0, 0);
        step(1, 1, 0, Z, 0, 0, 0, 0);
        step(1, 1, 0, Z, 1, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            if (OVL == 1) k = (i + 1 > 3) ? 3 : i + 1;
            else          k = (i / 4 + 1 > 3) ? 3 : i / 4 + 1;
            step(1, 1, 0, Z, 1, (OVL == 1) || (i % 4 == 0), k, k == 3);
        end
        step(1, 1, 1, Z, 1, 0, 0, 0);
        step(1, 1, 0, Z, 1, 1, 1, 0);

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
